// File: rtl/decimal_entry_to_signed_pkg.sv
// Shared constants, FSM state encoding and the Horner step for decimal_entry_to_signed.
package decimal_entry_to_signed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        CONV  = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam int MAX_DIGITS = 3;
    localparam int POS_LIMIT  = 127;
    localparam int NEG_LIMIT  = 128;
    localparam int ACC_W      = 10;

    // 99*10+9 is the largest intermediate, so ACC_W bits never overflow.
    function automatic logic [ACC_W-1:0] horner_step(input logic [ACC_W-1:0] acc,
                                                     input logic [3:0]       d);
        return acc * ACC_W'(10) + ACC_W'(d);
    endfunction

endpackage

// File: rtl/decimal_entry_to_signed_if.sv
// Keystroke and result bundle between the board input logic and the entry converter.
interface decimal_entry_to_signed_if;
    import decimal_entry_to_signed_pkg::*;

    // Strobes are single-cycle with no ready: the converter accepts them whenever
    // busy is low and silently drops them while busy is high.
    logic       digit_valid;
    logic [3:0] digit;
    logic       neg_toggle;
    logic       enter;
    logic       clear;
    logic [3:0] entry_dig0;
    logic [3:0] entry_dig1;
    logic [3:0] entry_dig2;
    logic       entry_neg;
    logic       busy;
    logic [7:0] val;
    logic       val_valid;
    logic       range_err;
    state_t     fsm_state;

    modport master (
        output digit_valid, digit, neg_toggle, enter, clear,
        input  entry_dig0, entry_dig1, entry_dig2, entry_neg,
        input  busy, val, val_valid, range_err, fsm_state
    );

    modport slave (
        input  digit_valid, digit, neg_toggle, enter, clear,
        output entry_dig0, entry_dig1, entry_dig2, entry_neg,
        output busy, val, val_valid, range_err, fsm_state
    );

endinterface

// File: rtl/decimal_entry_to_signed_bcd_entry_shift.sv
// Three-digit BCD shift register with saturating stroke count and entry sign flop.
module bcd_entry_shift
    import decimal_entry_to_signed_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift_en,
    input  logic       toggle,
    input  logic [3:0] digit,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic       neg,
    output logic [1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            dig0  <= 4'd0;
            dig1  <= 4'd0;
            dig2  <= 4'd0;
            neg   <= 1'b0;
            count <= 2'd0;
        end else begin
            // Strokes beyond the third are dropped rather than pushing digits out.
            if (shift_en && (count != 2'(MAX_DIGITS))) begin
                dig2  <= dig1;
                dig1  <= dig0;
                dig0  <= digit;
                count <= count + 2'd1;
            end
            if (toggle) begin
                neg <= ~neg;
            end
        end
    end

endmodule

// File: rtl/decimal_entry_to_signed.sv
// Decimal entry FSM, Horner accumulator and signed range check.
// Build option: DECIMAL_ENTRY_SATURATE_EN clamps out-of-range entries instead of dropping them.
module decimal_entry_to_signed
    import decimal_entry_to_signed_pkg::*;
(
    input logic                        clk,
    input logic                        rst,
    decimal_entry_to_signed_if.slave   bus
);

    state_t           state;
    state_t           state_n;
    logic             accept;
    logic             digit_ok;
    logic             do_clear;
    logic             do_enter;
    logic             do_toggle;
    logic             do_shift;
    logic             clr_entry;
    logic [3:0]       dig0;
    logic [3:0]       dig1;
    logic [3:0]       dig2;
    logic             neg;
    logic [1:0]       count;
    logic [ACC_W-1:0] acc;
    logic [1:0]       conv_step;
    logic [3:0]       conv_digit;
    logic [ACC_W-1:0] limit;
    logic             in_range;
    logic [7:0]       mag_val;
`ifdef DECIMAL_ENTRY_SATURATE_EN
    logic [7:0]       sat_val;
`endif

    // One action per cycle, in priority order clear > enter > sign > digit.
    assign accept    = (state == IDLE) || (state == ENTRY);
    assign digit_ok  = bus.digit_valid && (bus.digit <= 4'd9);
    assign do_clear  = accept && bus.clear;
    assign do_enter  = accept && !bus.clear && bus.enter;
    assign do_toggle = accept && !bus.clear && !bus.enter && bus.neg_toggle;
    assign do_shift  = accept && !bus.clear && !bus.enter && !bus.neg_toggle && digit_ok;
    assign clr_entry = do_clear || (state == CHECK);

    bcd_entry_shift u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_entry),
        .shift_en (do_shift),
        .toggle   (do_toggle),
        .digit    (bus.digit),
        .dig0     (dig0),
        .dig1     (dig1),
        .dig2     (dig2),
        .neg      (neg),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, ENTRY: begin
                if (do_clear) begin
                    state_n = IDLE;
                end else if (do_enter) begin
                    state_n = CONV;
                end else if (do_shift) begin
                    state_n = ENTRY;
                end
            end
            CONV:    if (conv_step == 2'd2) state_n = CHECK;
            CHECK:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Horner order is most significant digit first.
    always_comb begin
        conv_digit = dig0;
        case (conv_step)
            2'd0:    conv_digit = dig2;
            2'd1:    conv_digit = dig1;
            default: conv_digit = dig0;
        endcase
    end

    assign limit    = neg ? ACC_W'(NEG_LIMIT) : ACC_W'(POS_LIMIT);
    assign in_range = (acc <= limit);
    assign mag_val  = neg ? (~acc[7:0] + 8'd1) : acc[7:0];
`ifdef DECIMAL_ENTRY_SATURATE_EN
    assign sat_val  = neg ? 8'h80 : 8'h7F;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            conv_step     <= 2'd0;
            bus.val       <= 8'h00;
            bus.val_valid <= 1'b0;
            bus.range_err <= 1'b0;
        end else begin
            bus.val_valid <= 1'b0;
            bus.range_err <= 1'b0;
            if (do_enter) begin
                acc       <= '0;
                conv_step <= 2'd0;
            end else if (state == CONV) begin
                acc       <= horner_step(acc, conv_digit);
                conv_step <= conv_step + 2'd1;
            end
            if (state == CHECK) begin
                if (in_range) begin
                    bus.val       <= mag_val;
                    bus.val_valid <= 1'b1;
                end else begin
`ifdef DECIMAL_ENTRY_SATURATE_EN
                    bus.val       <= sat_val;
                    bus.val_valid <= 1'b1;
`endif
                    bus.range_err <= 1'b1;
                end
            end
        end
    end

    assign bus.entry_dig0 = dig0;
    assign bus.entry_dig1 = dig1;
    assign bus.entry_dig2 = dig2;
    assign bus.entry_neg  = neg;
    assign bus.busy       = (state == CONV) || (state == CHECK);
    assign bus.fsm_state  = state;

endmodule

// File: tb/tb_decimal_entry_to_signed.sv
// Directed bench for decimal_entry_to_signed: entry, conversion, range limits, priority and reset.
module tb_decimal_entry_to_signed;
    import decimal_entry_to_signed_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    decimal_entry_to_signed_if bus();

    decimal_entry_to_signed dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        step();
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
    endtask

    task automatic toggle();
        bus.neg_toggle = 1'b1;
        step();
        bus.neg_toggle = 1'b0;
    endtask

    task automatic chk_entry(input string tag, input logic [3:0] d2, input logic [3:0] d1,
                             input logic [3:0] d0, input logic n);
        chk({tag, "_dig2"}, 10'(bus.entry_dig2), 10'(d2));
        chk({tag, "_dig1"}, 10'(bus.entry_dig1), 10'(d1));
        chk({tag, "_dig0"}, 10'(bus.entry_dig0), 10'(d0));
        chk({tag, "_neg"},  10'(bus.entry_neg),  10'(n));
    endtask

    // enter at edge N; busy through the CHECK cycle, results registered at N+4.
    task automatic convert(input string tag, input logic [7:0] ev, input logic evv,
                           input logic ere, input logic junk);
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        chk({tag, "_busy_n"}, 10'(bus.busy), 10'd1);
        chk({tag, "_vv_n"}, 10'(bus.val_valid), 10'd0);
        if (junk) begin
            bus.clear       = 1'b1;
            bus.enter       = 1'b1;
            bus.neg_toggle  = 1'b1;
            bus.digit_valid = 1'b1;
            bus.digit       = 4'd5;
        end
        step();
        step();
        step();
        chk({tag, "_busy_n3"}, 10'(bus.busy), 10'd1);
        chk({tag, "_state_n3"}, 10'(bus.fsm_state), 10'(CHECK));
        step();
        bus.clear       = 1'b0;
        bus.enter       = 1'b0;
        bus.neg_toggle  = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        chk({tag, "_val"}, 10'(bus.val), 10'(ev));
        chk({tag, "_vv"}, 10'(bus.val_valid), 10'(evv));
        chk({tag, "_re"}, 10'(bus.range_err), 10'(ere));
        chk({tag, "_busy_n4"}, 10'(bus.busy), 10'd0);
        chk({tag, "_state_n4"}, 10'(bus.fsm_state), 10'(IDLE));
        chk_entry({tag, "_cleared"}, 4'd0, 4'd0, 4'd0, 1'b0);
        step();
        chk({tag, "_vv_drop"}, 10'(bus.val_valid), 10'd0);
        chk({tag, "_re_drop"}, 10'(bus.range_err), 10'd0);
    endtask

    initial begin
        logic [7:0] keep_val;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.neg_toggle  = 1'b0;
        bus.enter       = 1'b0;
        bus.clear       = 1'b0;

        // Reset values
        step();
        step();
        rst = 1'b0;
        chk_entry("rst", 4'd0, 4'd0, 4'd0, 1'b0);
        chk("rst_val", 10'(bus.val), 10'h00);
        chk("rst_vv", 10'(bus.val_valid), 10'd0);
        chk("rst_re", 10'(bus.range_err), 10'd0);
        chk("rst_busy", 10'(bus.busy), 10'd0);
        chk("rst_state", 10'(bus.fsm_state), 10'(IDLE));

        // +127: upper positive limit
        key(4'd1);
        chk("first_dig0", 10'(bus.entry_dig0), 10'd1);
        chk("first_state", 10'(bus.fsm_state), 10'(ENTRY));
        key(4'd2);
        key(4'd7);
        chk_entry("e127", 4'd1, 4'd2, 4'd7, 1'b0);
        convert("c127", 8'h7F, 1'b1, 1'b0, 1'b0);

        // -128: lower negative limit
        toggle();
        chk("tog_neg", 10'(bus.entry_neg), 10'd1);
        chk("tog_state", 10'(bus.fsm_state), 10'(IDLE));
        key(4'd1);
        key(4'd2);
        key(4'd8);
        chk_entry("e_m128", 4'd1, 4'd2, 4'd8, 1'b1);
        convert("c_m128", 8'h80, 1'b1, 1'b0, 1'b0);

        // +200: out of range
        key(4'd2);
        key(4'd0);
        key(4'd0);
`ifdef DECIMAL_ENTRY_SATURATE_EN
        convert("c200", 8'h7F, 1'b1, 1'b1, 1'b0);
        keep_val = 8'h7F;
`else
        convert("c200", 8'h80, 1'b0, 1'b1, 1'b0);
        keep_val = 8'h80;
`endif

        // Saturating digit count, illegal code, clear beats toggle
        key(4'd1);
        key(4'd2);
        key(4'd3);
        key(4'd4);
        chk_entry("sat4", 4'd1, 4'd2, 4'd3, 1'b0);
        key(4'd12);
        chk_entry("illegal", 4'd1, 4'd2, 4'd3, 1'b0);
        bus.neg_toggle = 1'b1;
        bus.clear      = 1'b1;
        step();
        bus.neg_toggle = 1'b0;
        bus.clear      = 1'b0;
        chk_entry("clr_tog", 4'd0, 4'd0, 4'd0, 1'b0);
        chk("clr_val", 10'(bus.val), 10'(keep_val));
        chk("clr_state", 10'(bus.fsm_state), 10'(IDLE));

        // Sign beats a digit in the same cycle
        bus.neg_toggle  = 1'b1;
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd6;
        step();
        bus.neg_toggle  = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        chk_entry("tog_digit", 4'd0, 4'd0, 4'd0, 1'b1);
        chk("tog_digit_state", 10'(bus.fsm_state), 10'(IDLE));

        // -0 from IDLE commits 0x00; strobes during busy are ignored
        convert("c_m0", 8'h00, 1'b1, 1'b0, 1'b1);

        // -129: negative out of range
        toggle();
        key(4'd1);
        key(4'd2);
        key(4'd9);
`ifdef DECIMAL_ENTRY_SATURATE_EN
        convert("c_m129", 8'h80, 1'b1, 1'b1, 1'b0);
`else
        convert("c_m129", 8'h00, 1'b0, 1'b1, 1'b0);
`endif

        // -5 two's complement
        toggle();
        key(4'd5);
        convert("c_m5", 8'hFB, 1'b1, 1'b0, 1'b0);

        // Reset during CONV
        key(4'd9);
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        step();
        chk("pre_rst_state", 10'(bus.fsm_state), 10'(CONV));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_entry("mid_rst", 4'd0, 4'd0, 4'd0, 1'b0);
        chk("mid_rst_val", 10'(bus.val), 10'h00);
        chk("mid_rst_vv", 10'(bus.val_valid), 10'd0);
        chk("mid_rst_re", 10'(bus.range_err), 10'd0);
        chk("mid_rst_busy", 10'(bus.busy), 10'd0);
        chk("mid_rst_state", 10'(bus.fsm_state), 10'(IDLE));
        step();
        step();
        chk("post_rst_vv", 10'(bus.val_valid), 10'd0);
        chk("post_rst_val", 10'(bus.val), 10'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
